// File: rtl/mult_if.sv
// mult_if: start/ready handshake and operand/product bus of the shared serial multiplier.
interface mult_if #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 8
);
  logic                       start_i;
  logic [WIDTH_A-1:0]         a_i;
  logic [WIDTH_B-1:0]         b_i;
  logic                       ready_o;
  logic                       busy_o;
  logic [WIDTH_A+WIDTH_B-1:0] prod_o;
  modport master (output start_i, a_i, b_i, input ready_o, busy_o, prod_o);
  modport slave  (input start_i, a_i, b_i, output ready_o, busy_o, prod_o);
endinterface

// File: rtl/mult_serial.sv
// mult_serial: shift-add signed x unsigned multiplier, one multiplier bit per cycle, fixed latency.
module mult_serial #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 8
) (
  input logic   clk_i,
  input logic   rst_ni,
  mult_if.slave bus
);
  localparam int P  = WIDTH_A + WIDTH_B;
  localparam int CW = $clog2(WIDTH_B);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e            state_q, state_d;
  logic [P-1:0]      acc_q, acc_d, a_sh_q, a_sh_d, prod_q, prod_d, acc_sum;
  logic [WIDTH_B-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
  always_comb begin
    acc_sum = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        a_sh_d  = {{WIDTH_B{bus.a_i[WIDTH_A-1]}}, bus.a_i};
        b_sh_d  = bus.b_i;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        // the product register captures the final sum on the same edge that enters DONE
        if (cnt_q == CW'(WIDTH_B - 1)) begin
          state_d = DONE;
          prod_d  = acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.ready_o = state_q == DONE;
  assign bus.busy_o  = state_q != IDLE;
  assign bus.prod_o  = prod_q;
endmodule

// File: tb/tb_mult_serial.sv
// tb_mult_serial: directed corner cases plus random back-to-back multiplies against an arithmetic model.
module tb_mult_serial;
  logic clk, rst_n;
  int   n_vec = 0, n_err = 0;
  mult_if #(.WIDTH_A(16), .WIDTH_B(8)) bus ();
  mult_serial #(.WIDTH_A(16), .WIDTH_B(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] ref_mul(input logic [15:0] a, input logic [7:0] b);
    longint p;
    p = longint'($signed(a)) * longint'({1'b0, b});
    return p[23:0];
  endfunction
  task automatic run(input logic [15:0] a, input logic [7:0] b, input bit noise);
    int n;
    logic [23:0] e;
    e = ref_mul(a, b);
    bus.start_i = 1;
    bus.a_i = a;
    bus.b_i = b;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      bus.start_i = 0;
      if (n == 1) chk("busy", 32'(bus.busy_o), 1);
      if (noise) begin
        bus.a_i = 16'($urandom);
        bus.b_i = 8'($urandom);
        bus.start_i = (n == 2 || n == 8);
      end
    end while (!bus.ready_o && n < 20);
    chk("latency", n, 9);
    chk("prod", 32'(bus.prod_o), 32'(e));
    @(posedge clk); #1;
    bus.start_i = 0;
    chk("pulse_width", 32'(bus.ready_o), 0);
    chk("idle_after", 32'(bus.busy_o), 0);
    chk("prod_hold", 32'(bus.prod_o), 32'(e));
  endtask
  initial begin
    rst_n = 0;
    bus.start_i = 0;
    bus.a_i = '0;
    bus.b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_prod", 32'(bus.prod_o), 0);
    rst_n = 1;
    @(posedge clk); #1;
    run(16'h7FFF, 8'hFF, 0);
    run(16'h8000, 8'hFF, 0);
    run(16'hFFFF, 8'h01, 0);
    run(16'h1234, 8'h00, 0);
    run(16'h7FFF, 8'hFF, 0);
    run(16'h0000, 8'hA5, 0);
    run(16'hC3A1, 8'h5B, 1);
    run(16'h0123, 8'hFE, 1);
    bus.start_i = 1;
    bus.a_i = 16'h4321;
    bus.b_i = 8'h77;
    @(posedge clk); #1;
    bus.start_i = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("abort_busy", 32'(bus.busy_o), 0);
    chk("abort_ready", 32'(bus.ready_o), 0);
    chk("abort_prod", 32'(bus.prod_o), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_ready", 32'(bus.ready_o), 0);
    chk("abort_prod_held", 32'(bus.prod_o), 0);
    rst_n = 1;
    @(posedge clk); #1;
    run(16'hABCD, 8'h3C, 0);
    for (int i = 0; i < 3000; i++)
      run(16'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
